// File: rtl/hpi_if.sv
// HPI host strobes/data plus the device-side mailbox port of hpi_target.
`timescale 1ns/1ps
interface hpi_if;
  // Handshake: an access is open while hpi_cs_n and hpi_r_n (or hpi_w_n) are low.
  // The target performs exactly one side effect per strobe assertion. It drives
  // read data only while hpi_data_oe is high. Mailbox flags move on single-cycle
  // mbx_in_ack / mbx_out_wr pulses.
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic        hpi_cs_n;
  logic        hpi_rst_n;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;

  modport slave (
    input  hpi_addr, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n,
           mbx_in_ack, mbx_out_data, mbx_out_wr,
    output hpi_data_out, hpi_data_oe, mbx_in_data, mbx_in_valid
  );

  modport master (
    output hpi_addr, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n,
           mbx_in_ack, mbx_out_data, mbx_out_wr,
    input  hpi_data_out, hpi_data_oe, mbx_in_data, mbx_in_valid
  );
endinterface

// File: rtl/hpi_target.sv
// HPI device-side responder: shared RAM with auto-increment pointer, mailbox and status.
`timescale 1ns/1ps
module hpi_target #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  hpi_if.slave       hpi,
  output logic [2:0] dbg_state_o
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_FETCH = 3'd1;
  localparam logic [2:0] S_RD_DRIVE = 3'd2;
  localparam logic [2:0] S_WR_DO    = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_MBX  = 2'd1;
  localparam logic [1:0] SEL_ADDR = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync_q, w_sync_q, cs_sync_q, rst_sync_q;
  logic        rd, wr, hrst_n;
  logic [2:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic [15:0] mbx_in_q, mbx_in_d;
  logic [15:0] mbx_out_q, mbx_out_d;
  logic        in_valid_q, in_valid_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;
  logic        ram_we;
  logic [15:0] rd_val;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync_q   <= '1;
      w_sync_q   <= '1;
      cs_sync_q  <= '1;
      rst_sync_q <= '1;
    end else begin
      r_sync_q   <= {r_sync_q[SYNC_STAGES-2:0], hpi.hpi_r_n};
      w_sync_q   <= {w_sync_q[SYNC_STAGES-2:0], hpi.hpi_w_n};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], hpi.hpi_cs_n};
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], hpi.hpi_rst_n};
    end
  end

  assign rd       = ~cs_sync_q[SYNC_STAGES-1] & ~r_sync_q[SYNC_STAGES-1];
  assign wr       = ~cs_sync_q[SYNC_STAGES-1] & ~w_sync_q[SYNC_STAGES-1];
  assign hrst_n   = rst_sync_q[SYNC_STAGES-1];
  // Byte address: bit 0 ignored, bits above ADDR_W alias the RAM.
  assign word_idx = addr_q[ADDR_W:1];

  always_comb begin
    rd_val = 16'h0000;
    case (sel_q)
      SEL_DATA: rd_val = mem[word_idx];
      SEL_MBX:  rd_val = mbx_out_q;
      SEL_ADDR: rd_val = addr_q;
      SEL_STAT: rd_val = {13'b0, err_q, in_valid_q, out_valid_q};
      default:  rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    mbx_in_d    = mbx_in_q;
    mbx_out_d   = mbx_out_q;
    in_valid_d  = in_valid_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    ram_we      = 1'b0;

    // Ack first so a coincident host MAILBOX write below wins.
    if (hpi.mbx_in_ack) in_valid_d = 1'b0;

    if (!hrst_n) begin
      state_d     = S_IDLE;
      oe_d        = 1'b0;
      addr_d      = 16'h0000;
      in_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd && wr) begin
            state_d = S_RELEASE;
            err_d   = 1'b1;
          end else if (rd) begin
            state_d = S_RD_FETCH;
            sel_d   = hpi.hpi_addr;
          end else if (wr) begin
            state_d = S_WR_DO;
            sel_d   = hpi.hpi_addr;
            wdata_d = hpi.hpi_data_in;
          end
        end
        S_RD_FETCH: begin
          state_d = S_RD_DRIVE;
          dout_d  = rd_val;
          oe_d    = 1'b1;
        end
        S_RD_DRIVE: begin
          state_d = S_RELEASE;
          case (sel_q)
            SEL_DATA: addr_d      = addr_q + 16'd2;
            SEL_MBX:  out_valid_d = 1'b0;
            SEL_STAT: err_d       = 1'b0;
            default:  ;
          endcase
        end
        S_WR_DO: begin
          state_d = S_RELEASE;
          case (sel_q)
            SEL_DATA: begin
              ram_we = 1'b1;
              addr_d = addr_q + 16'd2;
            end
            SEL_MBX: begin
              mbx_in_d   = wdata_q;
              in_valid_d = 1'b1;
            end
            SEL_ADDR: addr_d = wdata_q;
            default:  ;
          endcase
        end
        S_RELEASE: begin
          if (!rd && !wr) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Device post beats a same-cycle host MAILBOX-read clear.
    if (hpi.mbx_out_wr) begin
      mbx_out_d   = hpi.mbx_out_data;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_DATA;
      wdata_q     <= 16'h0000;
      addr_q      <= 16'h0000;
      dout_q      <= 16'h0000;
      oe_q        <= 1'b0;
      mbx_in_q    <= 16'h0000;
      mbx_out_q   <= 16'h0000;
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      mbx_in_q    <= mbx_in_d;
      mbx_out_q   <= mbx_out_d;
      in_valid_q  <= in_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // ram_we comes from state_q, which Reset clears asynchronously, so an aborted WR_DO never writes.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[word_idx] <= wdata_q;
  end

  assign hpi.hpi_data_out = dout_q;
  assign hpi.hpi_data_oe  = oe_q;
  assign hpi.mbx_in_data  = mbx_in_q;
  assign hpi.mbx_in_valid = in_valid_q;
  assign dbg_state_o      = state_q;
endmodule
